regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: maximum consecutive cycles alu_valid waits unserved before ALU gets forced priority.
REQ-002 SHALL have port clk  input  1  rising-edge clock shared with RegFile.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port alu_valid  input  1  ALU writeback request.
REQ-005 SHALL have port alu_reg  input  5  ALU destination register.
REQ-006 SHALL have port alu_data  input  32  ALU result.
REQ-007 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-008 SHALL have port mem_valid  input  1  load writeback request.
REQ-009 SHALL have port mem_reg  input  5  load destination register.
REQ-010 SHALL have port mem_data  input  32  load data.
REQ-011 SHALL have port mem_ready  output  1  load request accepted this cycle.
REQ-012 SHALL have port RegWrite  output  1  write strobe to RegFile.
REQ-013 SHALL have port WriteReg  output  5  RegFile write address.
REQ-014 SHALL have port WriteData  output  32  RegFile write data.
REQ-015 SHALL have port wb_count  output  16  count of committed non-$zero writes, wraps at 16'hFFFF -> 0.

Function
REQ-016 SHALL treat a transfer as valid&&ready on the rising edge of clk; requesters hold valid, reg and data stable until transfer.
REQ-017 SHALL derive alu_ready and mem_ready combinationally from valids and state; at most one ready high per cycle; neither high while rst=1.
REQ-018 SHALL implement two states: ARB (mem priority) and FORCE (alu priority).
REQ-019 In ARB: mem_valid -> mem_ready=1; else alu_valid -> alu_ready=1.
REQ-020 In FORCE: alu_valid -> alu_ready=1; else mem_valid -> mem_ready=1.
REQ-021 SHALL keep 2-bit-minimum starve counter: increments each cycle alu_valid=1 and alu_ready=0, clears on any ALU transfer or alu_valid=0, saturates at STARVE_LIMIT.
REQ-022 SHALL transition ARB->FORCE on the edge where the counter reaches STARVE_LIMIT; FORCE->ARB on the edge of an ALU transfer or when alu_valid=0.
REQ-023 SHALL register the winning request: RegWrite, WriteReg, WriteData valid the cycle after transfer (latency 1); RegFile commits on the following edge.
REQ-024 SHALL drive RegWrite=0 in any cycle not following a transfer; WriteReg/WriteData hold last values.
REQ-025 SHALL accept transfers with reg=0 (ready asserted normally) but SHALL suppress RegWrite and not increment wb_count for them.
REQ-026 SHALL increment wb_count by 1 in the same cycle RegWrite=1 is driven.
REQ-027 Simultaneous requests to the same register SHALL be serialized in grant order; the later grant's data is the final register value.
REQ-028 SHALL sustain one transfer per cycle with no bubble between back-to-back grants.

Reset
REQ-029 While rst=1 at a clk edge: RegWrite=0, WriteReg=0, WriteData=0, wb_count=0, state=ARB, starve counter=0.
REQ-030 A transfer registered in the cycle before rst SHALL be discarded: RegWrite=0 in the cycle after the reset edge.
REQ-031 Readies SHALL be 0 while rst=1; requests pending across reset are served normally after release.

Verification
REQ-032 Single ALU: alu_valid=1, alu_reg=5, alu_data=32'h1234 one cycle -> alu_ready=1 same cycle; next cycle RegWrite=1, WriteReg=5, WriteData=32'h1234; wb_count=1.
REQ-033 Collision: both valid, alu_reg=3/32'hA, mem_reg=4/32'hB -> cycle0 mem granted, cycle1 alu granted; RegWrite writes 4/B then 3/A on consecutive cycles.
REQ-034 Starvation: mem_valid held 1, alu_valid held 1, STARVE_LIMIT=3 -> mem granted 3 cycles, 4th cycle alu_ready=1, then mem resumes.
REQ-035 $zero: mem_valid=1, mem_reg=0, mem_data=32'hFFFFFFFF -> mem_ready=1, RegWrite stays 0, wb_count unchanged.
REQ-036 Reset mid-op: ALU transfer cycle N, rst=1 at edge N+1 -> RegWrite=0, wb_count=0, state ARB.
REQ-037 Wrap: preload 65535 writes -> next non-$zero write gives wb_count=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter in front of the register file. Loads win by default.
// An ALU request that has waited STARVE_LIMIT cycles takes priority for one grant.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    output logic [15:0] wb_count
);

    localparam int CW = ($clog2(STARVE_LIMIT + 1) > 2) ? $clog2(STARVE_LIMIT + 1) : 2;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {
        S_ARB,
        S_FORCE
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [CW-1:0]  r_starve;
    logic [CW-1:0]  w_starve_next;
    logic           w_alu_ready;
    logic           w_mem_ready;
    logic           w_xfer;
    logic [4:0]     w_sel_reg;
    logic [31:0]    w_sel_data;
    logic           r_reg_write;
    logic [4:0]     r_write_reg;
    logic [31:0]    r_write_data;
    logic [15:0]    r_wb_count;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_alu_ready   = 1'b0;
        w_mem_ready   = 1'b0;
        w_state_next  = r_state;
        w_starve_next = '0;

        if (!rst) begin
            case (r_state)
                S_ARB: begin
                    if (mem_valid)      w_mem_ready = 1'b1;
                    else if (alu_valid) w_alu_ready = 1'b1;
                end
                S_FORCE: begin
                    if (alu_valid)      w_alu_ready = 1'b1;
                    else if (mem_valid) w_mem_ready = 1'b1;
                end
                default: ;
            endcase
        end

        // Starve count saturates so a long wait cannot wrap back to zero.
        if (alu_valid && !w_alu_ready)
            w_starve_next = (r_starve == LIMIT) ? LIMIT : r_starve + CW'(1);

        case (r_state)
            S_ARB:   if (w_starve_next == LIMIT)        w_state_next = S_FORCE;
            S_FORCE: if (!alu_valid || w_alu_ready)     w_state_next = S_ARB;
            default:                                    w_state_next = S_ARB;
        endcase
    end

    assign w_xfer     = w_alu_ready | w_mem_ready;
    assign w_sel_reg  = w_alu_ready ? alu_reg  : mem_reg;
    assign w_sel_data = w_alu_ready ? alu_data : mem_data;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_ARB;
            r_starve     <= '0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_wb_count   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_starve    <= w_starve_next;
            // Writes to $zero are accepted but never strobed or counted.
            r_reg_write <= w_xfer && (w_sel_reg != 5'd0);
            if (w_xfer) begin
                r_write_reg  <= w_sel_reg;
                r_write_data <= w_sel_data;
            end
            if (w_xfer && (w_sel_reg != 5'd0))
                r_wb_count <= r_wb_count + 16'd1;
        end
    end

    assign alu_ready = w_alu_ready;
    assign mem_ready = w_mem_ready;
    assign RegWrite  = r_reg_write;
    assign WriteReg  = r_write_reg;
    assign WriteData = r_write_data;
    assign wb_count  = r_wb_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: hand-computed vector table, counter wrap run,
// then random traffic checked against a waited-cycles priority model.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 3;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [15:0] wb_count;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_reg   (mem_reg),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .wb_count  (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic [15:0] e_cnt;
        logic        chk_wd;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic s_ar, s_mr;

    // Reference model state
    int          m_wait;
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ar,
                                input logic [31:0] ad, input logic mv, input logic [4:0] mr,
                                input logic [31:0] md, input logic ea, input logic em,
                                input logic we, input logic [4:0] er, input logic [31:0] ed,
                                input logic [15:0] ec, input logic chk);
        vec_t v;
        v.rst = r;  v.av = av; v.ar = ar; v.ad = ad;
        v.mv = mv;  v.mr = mr; v.md = md;
        v.e_ar = ea; v.e_mr = em; v.e_we = we;
        v.e_reg = er; v.e_data = ed; v.e_cnt = ec; v.chk_wd = chk;
        return v;
    endfunction

    // Drive one cycle at the falling edge, sample readies mid-cycle, return just after the rising edge.
    task automatic apply(input logic r, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        @(negedge clk);
        rst = r; alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        #1;
        s_ar = alu_ready;
        s_mr = mem_ready;
        @(posedge clk);
        #1;
    endtask

    // ALU wins only once it has been refused LIMIT cycles in a row; otherwise loads go first.
    task automatic model_ready(input logic r, input logic av, input logic mv,
                               output logic ea, output logic em);
        ea = 1'b0;
        em = 1'b0;
        if (!r) begin
            if (m_wait >= LIMIT && av) ea = 1'b1;
            else if (mv)               em = 1'b1;
            else if (av)               ea = 1'b1;
        end
    endtask

    task automatic model_edge(input logic r, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic [4:0] mr, input logic [31:0] md,
                              input logic ea, input logic em);
        logic [4:0] reg_w;
        if (r) begin
            m_wait = 0; m_we = 1'b0; m_reg = '0; m_data = '0; m_cnt = '0;
        end else begin
            if (ea || em) begin
                reg_w  = ea ? ar : mr;
                m_data = ea ? ad : md;
                m_reg  = reg_w;
                m_we   = (reg_w != 5'd0);
                if (reg_w != 5'd0) m_cnt = m_cnt + 16'd1;
            end else begin
                m_we = 1'b0;
            end
            if (av && !ea) m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
            else           m_wait = 0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        av, mv, rr, ea, em;
        logic [4:0]  ar, mr;
        logic [31:0] ad, md;

        rst = 1'b1; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;

        //             rst av ar      ad            mv mr      md             ear emr we reg     data           cnt     chk
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,         0,  0,  0, 5'd0,  32'h0,         16'd0,  1));
        tbl.push_back(mk(1, 1, 5'd5,  32'h1234,     0, 5'd0,  32'h0,         0,  0,  0, 5'd0,  32'h0,         16'd0,  1));
        tbl.push_back(mk(0, 1, 5'd5,  32'h1234,     0, 5'd0,  32'h0,         1,  0,  1, 5'd5,  32'h1234,      16'd1,  1));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,         0,  0,  0, 5'd5,  32'h1234,      16'd1,  1));
        tbl.push_back(mk(0, 1, 5'd3,  32'hA,        1, 5'd4,  32'hB,         0,  1,  1, 5'd4,  32'hB,         16'd2,  1));
        tbl.push_back(mk(0, 1, 5'd3,  32'hA,        0, 5'd0,  32'h0,         1,  0,  1, 5'd3,  32'hA,         16'd3,  1));
        tbl.push_back(mk(0, 1, 5'd6,  32'h66,       1, 5'd7,  32'h70,        0,  1,  1, 5'd7,  32'h70,        16'd4,  1));
        tbl.push_back(mk(0, 1, 5'd6,  32'h66,       1, 5'd7,  32'h71,        0,  1,  1, 5'd7,  32'h71,        16'd5,  1));
        tbl.push_back(mk(0, 1, 5'd6,  32'h66,       1, 5'd7,  32'h72,        0,  1,  1, 5'd7,  32'h72,        16'd6,  1));
        tbl.push_back(mk(0, 1, 5'd6,  32'h66,       1, 5'd7,  32'h73,        1,  0,  1, 5'd6,  32'h66,        16'd7,  1));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd7,  32'h73,        0,  1,  1, 5'd7,  32'h73,        16'd8,  1));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd0,  32'hFFFFFFFF,  0,  1,  0, 5'd0,  32'h0,         16'd8,  0));
        tbl.push_back(mk(0, 1, 5'd8,  32'h88,       1, 5'd7,  32'h74,        0,  1,  1, 5'd7,  32'h74,        16'd9,  1));
        tbl.push_back(mk(0, 1, 5'd8,  32'h88,       1, 5'd7,  32'h75,        0,  1,  1, 5'd7,  32'h75,        16'd10, 1));
        tbl.push_back(mk(0, 1, 5'd8,  32'h88,       1, 5'd7,  32'h76,        0,  1,  1, 5'd7,  32'h76,        16'd11, 1));
        tbl.push_back(mk(1, 1, 5'd8,  32'h88,       1, 5'd7,  32'h77,        0,  0,  0, 5'd0,  32'h0,         16'd0,  1));
        tbl.push_back(mk(0, 1, 5'd8,  32'h88,       1, 5'd7,  32'h77,        0,  1,  1, 5'd7,  32'h77,        16'd1,  1));
        tbl.push_back(mk(0, 1, 5'd8,  32'h88,       0, 5'd0,  32'h0,         1,  0,  1, 5'd8,  32'h88,        16'd2,  1));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,         0,  0,  0, 5'd0,  32'h0,         16'd0,  1));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,         0,  0,  0, 5'd0,  32'h0,         16'd0,  1));
        tbl.push_back(mk(0, 1, 5'd0,  32'h5,        0, 5'd0,  32'h0,         1,  0,  0, 5'd0,  32'h0,         16'd0,  0));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd31, 32'hDEADBEEF,  0,  1,  1, 5'd31, 32'hDEADBEEF,  16'd1,  1));

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].mv, tbl[i].mr, tbl[i].md);
            check($sformatf("row%0d alu_ready", i), 32'(s_ar), 32'(tbl[i].e_ar));
            check($sformatf("row%0d mem_ready", i), 32'(s_mr), 32'(tbl[i].e_mr));
            check($sformatf("row%0d RegWrite", i), 32'(RegWrite), 32'(tbl[i].e_we));
            check($sformatf("row%0d wb_count", i), 32'(wb_count), 32'(tbl[i].e_cnt));
            if (tbl[i].chk_wd) begin
                check($sformatf("row%0d WriteReg", i), 32'(WriteReg), 32'(tbl[i].e_reg));
                check($sformatf("row%0d WriteData", i), WriteData, tbl[i].e_data);
            end
        end

        // Counter wrap: count is 1 here; 65534 more loads bring it to 16'hFFFF.
        @(negedge clk);
        rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'h5A5A;
        repeat (65534) @(posedge clk);
        #1;
        check("wrap pre wb_count", 32'(wb_count), 32'hFFFF);
        check("wrap pre RegWrite", 32'(RegWrite), 32'd1);
        apply(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hC0FFEE);
        check("wrap wb_count", 32'(wb_count), 32'h0);
        check("wrap RegWrite", 32'(RegWrite), 32'd1);
        check("wrap WriteReg", 32'(WriteReg), 32'd9);
        check("wrap WriteData", WriteData, 32'hC0FFEE);

        // Random traffic: requesters hold their request until it is accepted.
        av = 1'b0; mv = 1'b0; ar = '0; mr = '0; ad = '0; md = '0;
        m_wait = 0; m_we = 1'b0; m_reg = '0; m_data = '0; m_cnt = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!av && $urandom_range(0, 99) < 65) begin
                av = 1'b1; ar = 5'($urandom_range(0, 31)); ad = $urandom;
            end
            if (!mv && $urandom_range(0, 99) < 55) begin
                mv = 1'b1; mr = 5'($urandom_range(0, 31)); md = $urandom;
            end
            rr = (c == 0) || ($urandom_range(0, 63) == 0);
            model_ready(rr, av, mv, ea, em);
            apply(rr, av, ar, ad, mv, mr, md);
            model_edge(rr, av, ar, ad, mr, md, ea, em);
            check($sformatf("rnd%0d alu_ready", c), 32'(s_ar), 32'(ea));
            check($sformatf("rnd%0d mem_ready", c), 32'(s_mr), 32'(em));
            check($sformatf("rnd%0d RegWrite", c), 32'(RegWrite), 32'(m_we));
            check($sformatf("rnd%0d wb_count", c), 32'(wb_count), 32'(m_cnt));
            if (m_we) begin
                check($sformatf("rnd%0d WriteReg", c), 32'(WriteReg), 32'(m_reg));
                check($sformatf("rnd%0d WriteData", c), WriteData, m_data);
            end
            if (ea) av = 1'b0;
            if (em) mv = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
